// File: rtl/bw_edge_interp.sv
// Interpolates the threshold crossing between two spectrum bins into a
// fractional-bin edge using a restoring divider and one scale/add cycle.
module bw_edge_interp #(
  parameter int ACCUM_WIDTH     = 16,
  parameter int ACCUM_FRAC_BITS = 8,
  parameter int FREQ_BIN_WIDTH  = 9,
  parameter int THRESHOLD_DB    = 30,
  parameter int FRAC_BITS       = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                valid_i,
  input  logic                                edge_found_i,
  input  logic [FREQ_BIN_WIDTH-1:0]           f1_i,
  input  logic [FREQ_BIN_WIDTH-1:0]           f2_i,
  input  logic signed [ACCUM_WIDTH-1:0]       L1_i,
  input  logic signed [ACCUM_WIDTH-1:0]       L2_i,
  output logic [FREQ_BIN_WIDTH+FRAC_BITS-1:0] edge_o,
  output logic                                found_o,
  output logic                                err_o,
  output logic                                valid_o,
  output logic                                busy_o
);

  localparam int SW = ACCUM_WIDTH + 1;
  localparam int RW = ACCUM_WIDTH + 2;
  localparam int FW = FREQ_BIN_WIDTH;
  localparam int EW = FW + FRAC_BITS;
  localparam int CW = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;
  localparam int TI = -(THRESHOLD_DB * (2 ** ACCUM_FRAC_BITS));
  localparam logic signed [SW-1:0] T_S = SW'(TI);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    SCALE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [SW-1:0] num, den;
  logic [FW-1:0]        f1_q, df_q;
  logic [RW-1:0]        rem_q, den_q;
  logic [RW-1:0]        rem_sh, rem_sub;
  logic                 rem_ge;
  logic [FRAC_BITS-1:0] q_q;
  logic [CW-1:0]        cnt_q;
  logic [EW-1:0]        edge_q, dg_edge, scaled;
  logic                 found_q, err_q;
  logic                 degen, dg_err;

  assign num = T_S - SW'(L1_i);
  assign den = SW'(L2_i) - SW'(L1_i);

  assign rem_sh  = {rem_q[RW-2:0], 1'b0};
  assign rem_ge  = rem_sh >= den_q;
  assign rem_sub = rem_sh - den_q;

  // q < 2^FRAC_BITS keeps q*df below df<<FRAC_BITS, so the sum fits EW
  assign scaled = {f1_q, {FRAC_BITS{1'b0}}}
                + EW'(q_q) * EW'(df_q);

  always_comb begin
    degen   = 1'b1;
    dg_err  = 1'b1;
    dg_edge = '0;
    if (!edge_found_i) begin
      dg_err = 1'b0;
    end else if (f2_i <= f1_i) begin
      dg_edge = {f1_i, {FRAC_BITS{1'b0}}};
    end else if (den[SW-1] || den == '0) begin
      dg_edge = {f2_i, {FRAC_BITS{1'b0}}};
    end else if (num[SW-1]) begin
      dg_edge = {f1_i, {FRAC_BITS{1'b0}}};
    end else if (num >= den) begin
      dg_edge = {f2_i, {FRAC_BITS{1'b0}}};
    end else begin
      degen  = 1'b0;
      dg_err = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) state_d = degen ? DONE : DIVIDE;
      end
      DIVIDE: begin
        if (cnt_q == '0) state_d = SCALE;
      end
      SCALE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q == DONE);
    busy_o  = (state_q == DIVIDE) || (state_q == SCALE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f1_q    <= '0;
      df_q    <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            f1_q  <= f1_i;
            df_q  <= f2_i - f1_i;
            rem_q <= RW'($unsigned(num));
            den_q <= RW'($unsigned(den));
            q_q   <= '0;
            cnt_q <= CW'(FRAC_BITS - 1);
            if (degen) begin
              edge_q  <= dg_edge;
              err_q   <= dg_err;
              found_q <= edge_found_i;
            end
          end
        end
        DIVIDE: begin
          rem_q <= rem_ge ? rem_sub : rem_sh;
          q_q   <= {q_q[FRAC_BITS-2:0], rem_ge};
          cnt_q <= cnt_q - CW'(1);
        end
        SCALE: begin
          edge_q  <= scaled;
          found_q <= 1'b1;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign edge_o  = edge_q;
  assign found_o = found_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bw_edge_interp.sv
// Bench for bw_edge_interp: directed vector table, overrun and reset
// sequences, then randomized requests against a divide-based model.
module tb_bw_edge_interp;

  logic               clk = 1'b0;
  logic               rst_ni = 1'b0;
  logic               valid_i = 1'b0;
  logic               edge_found_i = 1'b0;
  logic [8:0]         f1_i = '0;
  logic [8:0]         f2_i = '0;
  logic signed [15:0] L1_i = '0;
  logic signed [15:0] L2_i = '0;
  logic [16:0]        edge_o;
  logic               found_o, err_o, valid_o, busy_o;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bw_edge_interp dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .edge_found_i(edge_found_i),
    .f1_i        (f1_i),
    .f2_i        (f2_i),
    .L1_i        (L1_i),
    .L2_i        (L2_i),
    .edge_o      (edge_o),
    .found_o     (found_o),
    .err_o       (err_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    int f1; int f2; int l1; int l2; bit fnd;
    int e; bit fo; bit er; int lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input longint act,
                       input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input int f1, input int f2, input int l1,
                       input int l2, input bit fnd);
    @(negedge clk);
    f1_i = 9'(f1);
    f2_i = 9'(f2);
    L1_i = 16'(l1);
    L2_i = 16'(l2);
    edge_found_i = fnd;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic request(input int f1, input int f2, input int l1,
                         input int l2, input bit fnd, output int lat,
                         output int e, output bit fo, output bit er);
    lat = -1;
    e = -1;
    fo = 1'b0;
    er = 1'b0;
    drive(f1, f2, l1, l2, fnd);
    for (int n = 1; n <= 20; n++) begin
      if (valid_o) begin
        lat = n;
        e = int'(edge_o);
        fo = found_o;
        er = err_o;
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      check("pulse_width", valid_o, 0);
    end
  endtask

  function automatic void model(input int f1, input int f2, input int l1,
                                input int l2, input bit fnd,
                                output int e, output bit fo,
                                output bit er, output int lat);
    int num, den, q;
    num = -30 * 256 - l1;
    den = l2 - l1;
    lat = 1;
    fo = fnd;
    er = 1'b1;
    e = 0;
    if (!fnd) er = 1'b0;
    else if (f2 <= f1) e = f1 * 256;
    else if (den <= 0) e = f2 * 256;
    else if (num < 0) e = f1 * 256;
    else if (num >= den) e = f2 * 256;
    else begin
      q = (num * 256) / den;
      e = f1 * 256 + q * (f2 - f1);
      er = 1'b0;
      lat = 10;
    end
  endfunction

  initial begin
    int lat, e, pulses, first, l1, l2, f1, f2;
    int me, mlat;
    bit fo, er, mfo, mer, fnd;

    vecs[0]  = '{100, 101, -8000, -7000, 1, 25681, 1, 0, 10};
    vecs[1]  = '{50, 52, -8192, -7168, 1, 13056, 1, 0, 10};
    vecs[2]  = '{100, 101, -7680, -7000, 1, 25600, 1, 0, 10};
    vecs[3]  = '{100, 101, -7680, -7680, 1, 25856, 1, 1, 1};
    vecs[4]  = '{100, 101, -8000, -7000, 0, 0, 0, 0, 1};
    vecs[5]  = '{101, 100, -8000, -7000, 1, 25856, 1, 1, 1};
    vecs[6]  = '{20, 30, -7000, -8000, 1, 7680, 1, 1, 1};
    vecs[7]  = '{20, 30, -7000, -6000, 1, 5120, 1, 1, 1};
    vecs[8]  = '{20, 30, -9000, -8000, 1, 7680, 1, 1, 1};
    vecs[9]  = '{20, 30, -8000, -7680, 1, 7680, 1, 1, 1};
    vecs[10] = '{200, 205, -7936, -7424, 1, 51840, 1, 0, 10};
    vecs[11] = '{0, 511, -32768, 32767, 1, 50078, 1, 0, 10};
    vecs[12] = '{510, 511, -8000, -7679, 1, 130815, 1, 0, 10};

    repeat (3) @(negedge clk);
    check("rst_edge", edge_o, 0);
    check("rst_found", found_o, 0);
    check("rst_err", err_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      request(vecs[i].f1, vecs[i].f2, vecs[i].l1, vecs[i].l2,
              vecs[i].fnd, lat, e, fo, er);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_edge", i), e, vecs[i].e);
      check($sformatf("v%0d_found", i), fo, vecs[i].fo);
      check($sformatf("v%0d_err", i), er, vecs[i].er);
    end

    // second request lands while the first is still dividing
    drive(100, 101, -8000, -7000, 1);
    pulses = 0;
    first = -1;
    e = -1;
    for (int n = 1; n <= 30; n++) begin
      if (valid_o) begin
        pulses++;
        if (first < 0) begin
          first = n;
          e = int'(edge_o);
        end
      end
      if (n == 3) begin
        f1_i = 9'd10;
        f2_i = 9'd11;
        valid_i = 1'b1;
      end
      if (n == 4) valid_i = 1'b0;
      if (n == 5) check("ovr_busy", busy_o, 1);
      @(negedge clk);
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_lat", first, 10);
    check("ovr_edge", e, 25681);

    // reset asserted mid-divide
    drive(100, 101, -8000, -7000, 1);
    repeat (3) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_edge", edge_o, 0);
    check("mid_rst_found", found_o, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    rst_ni = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    check("mid_rst_no_valid", pulses, 0);
    request(100, 101, -8000, -7000, 1, lat, e, fo, er);
    check("post_rst_lat", lat, 10);
    check("post_rst_edge", e, 25681);
    check("post_rst_err", er, 0);

    for (int i = 0; i < 40; i++) begin
      f1 = int'($urandom_range(0, 490));
      f2 = f1 + int'($urandom_range(0, 12)) - 2;
      if (f2 < 0) f2 = 0;
      fnd = ($urandom_range(0, 7) != 0);
      l1 = -7680 - int'($urandom_range(0, 3000)) + 200;
      l2 = l1 + int'($urandom_range(0, 4000)) - 300;
      model(f1, f2, l1, l2, fnd, me, mfo, mer, mlat);
      request(f1, f2, l1, l2, fnd, lat, e, fo, er);
      check($sformatf("r%0d_lat", i), lat, mlat);
      check($sformatf("r%0d_edge", i), e, me);
      check($sformatf("r%0d_found", i), fo, mfo);
      check($sformatf("r%0d_err", i), er, mer);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
